// File: rtl/sa_request_unit.sv
// Switch-allocator request stage: per input port, round-robin VC selection, registered
// output-port request held until a matching grant or a withdraw, then a one-cycle dequeue.
module sa_request_unit #(
    parameter int unsigned NUM_PORTS = 4,
    parameter int unsigned NUM_VCS   = 4
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic [NUM_PORTS-1:0][NUM_VCS-1:0]             vc_valid,
    input  logic [NUM_PORTS-1:0][NUM_VCS-1:0][NUM_PORTS-1:0] vc_out_port,
    input  logic [NUM_PORTS-1:0]                          out_credit,
    input  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]           allocated_ports,
    output logic [NUM_PORTS-1:0][NUM_PORTS-1:0]           port_requests,
    output logic [NUM_PORTS-1:0][NUM_VCS-1:0]             vc_dequeue,
    output logic [NUM_PORTS-1:0][NUM_VCS-1:0]             xbar_vc,
    output logic                                          grant_error
);

    localparam int unsigned VCW = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_REQ  = 1'b1;
    localparam logic [NUM_PORTS-1:0] ONE_P = {{(NUM_PORTS-1){1'b0}}, 1'b1};

    logic [NUM_PORTS-1:0]                    state_q, state_d;
    logic [NUM_PORTS-1:0][VCW-1:0]           rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0][VCW-1:0]           held_vc_q, held_vc_d;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]     req_q, req_d;
    logic [NUM_PORTS-1:0][NUM_VCS-1:0]       deq_q, deq_d;
    logic                                    grant_error_q, grant_error_d;

    logic [NUM_PORTS-1:0][NUM_VCS-1:0]       eligible;
    logic [NUM_PORTS-1:0]                    found;
    logic [NUM_PORTS-1:0][VCW-1:0]           sel_vc;

    // Eligible: valid head flit, exactly one-hot route, and credit on that output.
    always_comb begin
        logic [NUM_PORTS-1:0] route;
        eligible = '0;
        route    = '0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned v = 0; v < NUM_VCS; v++) begin
                route = vc_out_port[p][v];
                eligible[p][v] = vc_valid[p][v] && (route != '0) &&
                                 ((route & (route - ONE_P)) == '0) &&
                                 ((route & out_credit) != '0);
            end
        end
    end

    always_comb begin
        int unsigned idx;
        found  = '0;
        sel_vc = '0;
        idx    = 0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            for (int unsigned i = 0; i < NUM_VCS; i++) begin
                idx = (int'(rr_ptr_q[p]) + i) % NUM_VCS;
                if (!found[p] && eligible[p][idx]) begin
                    found[p]  = 1'b1;
                    sel_vc[p] = VCW'(idx);
                end
            end
        end
    end

    always_comb begin
        logic grant_hit;
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        held_vc_d     = held_vc_q;
        req_d         = req_q;
        deq_d         = '0;
        grant_error_d = grant_error_q;
        grant_hit     = 1'b0;
        for (int unsigned p = 0; p < NUM_PORTS; p++) begin
            grant_hit = (state_q[p] == ST_REQ) && (allocated_ports[p] == req_q[p]);
            // A grant that matches nothing is dropped and only flagged.
            if ((allocated_ports[p] != '0) && !grant_hit) begin
                grant_error_d = 1'b1;
            end
            if (state_q[p] == ST_IDLE) begin
                if (found[p]) begin
                    state_d[p]   = ST_REQ;
                    held_vc_d[p] = sel_vc[p];
                    req_d[p]     = vc_out_port[p][sel_vc[p]];
                end
            end else if (grant_hit) begin
                state_d[p]                = ST_IDLE;
                req_d[p]                  = '0;
                deq_d[p][held_vc_q[p]]    = 1'b1;
                rr_ptr_d[p]               = VCW'((int'(held_vc_q[p]) + 1) % NUM_VCS);
            end else if (!vc_valid[p][held_vc_q[p]] || ((req_q[p] & out_credit) == '0)) begin
                state_d[p] = ST_IDLE;
                req_d[p]   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= '0;
            rr_ptr_q      <= '0;
            held_vc_q     <= '0;
            req_q         <= '0;
            deq_q         <= '0;
            grant_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            held_vc_q     <= held_vc_d;
            req_q         <= req_d;
            deq_q         <= deq_d;
            grant_error_q <= grant_error_d;
        end
    end

    assign port_requests = req_q;
    assign vc_dequeue    = deq_q;
    assign xbar_vc       = deq_q;
    assign grant_error   = grant_error_q;

endmodule

// File: tb/tb_sa_request_unit.sv
// Scoreboard bench for sa_request_unit: directed scenarios then random traffic, checked
// against a per-port request/grant model.
module tb_sa_request_unit;

    localparam int NP = 4;
    localparam int NV = 4;

    logic clk = 1'b0;
    logic reset;
    logic [NP-1:0][NV-1:0]         vc_valid;
    logic [NP-1:0][NV-1:0][NP-1:0] vc_out_port;
    logic [NP-1:0]                 out_credit;
    logic [NP-1:0][NP-1:0]         allocated_ports;
    logic [NP-1:0][NP-1:0]         port_requests;
    logic [NP-1:0][NV-1:0]         vc_dequeue;
    logic [NP-1:0][NV-1:0]         xbar_vc;
    logic                          grant_error;

    always #5 clk = ~clk;

    sa_request_unit #(.NUM_PORTS(NP), .NUM_VCS(NV)) dut (
        .clk             (clk),
        .reset           (reset),
        .vc_valid        (vc_valid),
        .vc_out_port     (vc_out_port),
        .out_credit      (out_credit),
        .allocated_ports (allocated_ports),
        .port_requests   (port_requests),
        .vc_dequeue      (vc_dequeue),
        .xbar_vc         (xbar_vc),
        .grant_error     (grant_error)
    );

    typedef struct {int port; int vc;} deq_t;
    deq_t dq_q[$];
    deq_t e;

    // Model state: outstanding request per port (0 when idle), its VC, round-robin start.
    logic [NP-1:0] m_req [NP];
    int            m_vc  [NP];
    int            m_rr  [NP];
    logic          m_err;
    logic [NP-1:0] auto_grant;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input int p, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s[%0d]: got %0h expected %0h", name, p, act, exp);
    endtask

    task automatic clear_inputs();
        vc_valid        = '0;
        vc_out_port     = '0;
        out_credit      = '1;
        allocated_ports = '0;
        auto_grant      = '0;
    endtask

    // Apply current inputs, advance the model across the coming edge, wait for the next negedge.
    task automatic step();
        bit hit;
        bit done;
        int v;
        logic [NP-1:0] r;
        for (int p = 0; p < NP; p++) if (auto_grant[p]) allocated_ports[p] = m_req[p];
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                m_req[p] = '0; m_vc[p] = 0; m_rr[p] = 0;
            end
            m_err = 1'b0;
        end else begin
            for (int p = 0; p < NP; p++) begin
                hit = (m_req[p] != 0) && (allocated_ports[p] == m_req[p]);
                if (allocated_ports[p] != 0 && !hit) m_err = 1'b1;
                if (m_req[p] != 0) begin
                    if (hit) begin
                        dq_q.push_back('{p, m_vc[p]});
                        m_rr[p]  = (m_vc[p] + 1) % NV;
                        m_req[p] = '0;
                    end else if (!vc_valid[p][m_vc[p]] || (m_req[p] & out_credit) == 0) begin
                        m_req[p] = '0;
                    end
                end else begin
                    done = 0;
                    for (int k = 0; k < NV; k++) begin
                        v = (m_rr[p] + k) % NV;
                        r = vc_out_port[p][v];
                        if (!done && vc_valid[p][v] && $countones(r) == 1 &&
                            (r & out_credit) != 0) begin
                            done = 1; m_vc[p] = v; m_req[p] = r;
                        end
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic randomize_inputs();
        int x;
        for (int p = 0; p < NP; p++) begin
            for (int v = 0; v < NV; v++) begin
                vc_valid[p][v] = ($urandom_range(0, 3) != 0);
                x = $urandom_range(0, 9);
                if (x == 0) vc_out_port[p][v] = '0;
                else if (x == 1) vc_out_port[p][v] = NP'($urandom_range(0, 15));
                else vc_out_port[p][v] = NP'(1 << $urandom_range(0, NP - 1));
            end
            out_credit[p] = ($urandom_range(0, 4) != 0);
            x = $urandom_range(0, 99);
            if (m_req[p] != 0) begin
                if (x < 50) allocated_ports[p] = m_req[p];
                else if (x < 53) allocated_ports[p] = m_req[p] ^ NP'(1 << $urandom_range(0, NP - 1));
                else allocated_ports[p] = '0;
            end else begin
                allocated_ports[p] = (x < 2) ? NP'(1 << $urandom_range(0, NP - 1)) : '0;
            end
        end
        reset = ($urandom_range(0, 199) == 0);
    endtask

    // Monitor: per-cycle request/error checks; dequeue pulses pop the scoreboard.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int p = 0; p < NP; p++) begin
                chk("port_requests", p, 32'(port_requests[p]), 32'(m_req[p]));
                if (vc_dequeue[p] != 0 || xbar_vc[p] != 0) begin
                    if (dq_q.size() == 0 || dq_q[0].port != p) begin
                        checks++;
                        $display("FAIL unexpected_dequeue[%0d]: got %0h expected 0", p,
                                 vc_dequeue[p]);
                    end else begin
                        e = dq_q.pop_front();
                        chk("vc_dequeue", p, 32'(vc_dequeue[p]), 32'(1 << e.vc));
                        chk("xbar_vc", p, 32'(xbar_vc[p]), 32'(1 << e.vc));
                    end
                end
            end
            checks++;
            if (dq_q.size() != 0) begin
                $display("FAIL missing_dequeue[%0d]: got 0 expected %0h", dq_q[0].port,
                         1 << dq_q[0].vc);
                dq_q.delete();
            end else begin
                passed++;
            end
            chk("grant_error", 0, 32'(grant_error), 32'(m_err));
        end
    end

    initial begin
        m_err = 1'b0;
        for (int p = 0; p < NP; p++) begin
            m_req[p] = '0; m_vc[p] = 0; m_rr[p] = 0;
        end
        clear_inputs();
        // Reset held two cycles with all inputs active.
        reset = 1'b1;
        vc_valid = '1;
        for (int p = 0; p < NP; p++)
            for (int v = 0; v < NV; v++) vc_out_port[p][v] = NP'(1 << ((p + v) % NP));
        allocated_ports = '1;
        step(); step();
        reset = 1'b0;
        allocated_ports = '0;
        step(); step();
        reset = 1'b1; clear_inputs(); step(); reset = 1'b0;

        // Single request, grant three cycles later.
        vc_valid[0][2] = 1'b1; vc_out_port[0][2] = 4'b0100;
        step(); step(); step();
        allocated_ports[0] = 4'b0100; step();
        clear_inputs(); step(); step();

        // Round-robin with immediate grants.
        vc_valid[1] = '1;
        for (int v = 0; v < NV; v++) vc_out_port[1][v] = 4'b0001;
        auto_grant[1] = 1'b1;
        repeat (11) step();
        clear_inputs(); step(); step();

        // Withdraw on credit loss, then re-request.
        vc_valid[2][1] = 1'b1; vc_out_port[2][1] = 4'b1000;
        step(); step();
        out_credit[3] = 1'b0; step(); step();
        out_credit[3] = 1'b1; step(); step();
        // Grant and credit drop together.
        allocated_ports[2] = 4'b1000; out_credit[3] = 1'b0; step();
        clear_inputs(); step(); step();

        // Spurious grants: idle, then mismatched while requesting.
        allocated_ports[3] = 4'b0010; step();
        allocated_ports[3] = '0; step();
        vc_valid[3][0] = 1'b1; vc_out_port[3][0] = 4'b0001; step(); step();
        allocated_ports[3] = 4'b0011; step();
        allocated_ports[3] = '0; step(); step();
        allocated_ports[3] = 4'b0001; step();
        clear_inputs(); step();

        // Reset mid-request, coinciding with a grant.
        vc_valid[0][0] = 1'b1; vc_out_port[0][0] = 4'b0010; step(); step();
        allocated_ports[0] = 4'b0010; reset = 1'b1; step();
        reset = 1'b0; clear_inputs(); step(); step();

        repeat (3000) begin
            randomize_inputs();
            step();
        end
        reset = 1'b0; clear_inputs(); step();
        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/sa_request_unit.md
# sa_request_unit

Upstream stage of the switch allocator in the virtual-channel router. For each input port it picks one eligible VC by round-robin, registers that VC's one-hot output-port request onto `port_requests`, and holds it until the switch allocator returns a matching grant on `allocated_ports`. On a grant it pulses a dequeue strobe for the winning VC. Its outputs feed the switch allocator's request inputs and the crossbar's VC-select.

## Interface
- `NUM_PORTS`, 4: router input/output port count; also the request width.
- `NUM_VCS`, 4: VCs per input port.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `vc_valid[NUM_PORTS-1:0]`  in  NUM_VCS each  per input port: VC holds a head flit ready for switch allocation.
- `vc_out_port[NUM_PORTS-1:0][NUM_VCS-1:0]`  in  NUM_PORTS each  routed output port per VC, one-hot.
- `out_credit`  in  NUM_PORTS  output port p has at least one downstream credit.
- `allocated_ports[NUM_PORTS-1:0]`  in  NUM_PORTS each  grants from the switch allocator, per input port.
- `port_requests[NUM_PORTS-1:0]`  out  NUM_PORTS each  registered requests to the switch allocator.
- `vc_dequeue[NUM_PORTS-1:0]`  out  NUM_VCS each  one-cycle one-hot pulse: pop the head flit of that VC.
- `xbar_vc[NUM_PORTS-1:0]`  out  NUM_VCS each  registered one-hot VC driving the crossbar; same cycle as `vc_dequeue`.
- `grant_error`  out  1  sticky error flag; cleared only by reset.

## Operation
- Each input port p runs an independent 2-state FSM, IDLE/REQ, plus a round-robin pointer `rr_ptr[p]` (log2 NUM_VCS bits) and a latched `held_vc[p]`.
- VC v of port p is eligible when all three hold: `vc_valid[p][v]` = 1; `vc_out_port[p][v]` is exactly one-hot; and the credit bit for that output port is 1. Zero-hot or multi-hot routes are never eligible.
- IDLE: select the first eligible VC searching from `rr_ptr[p]` upward with wrap-around. If one exists, go to REQ, latch `held_vc`, and register `port_requests[p]` = `vc_out_port[p][held_vc]`.
- REQ: `port_requests[p]` is held constant. Three cases:
  - Grant: `allocated_ports[p] == port_requests[p]`. Next cycle `vc_dequeue[p]` = `xbar_vc[p]` = onehot(`held_vc`) for one cycle. `port_requests[p]` goes to 0, state returns to IDLE, and `rr_ptr[p]` = (`held_vc`+1) mod NUM_VCS.
  - Withdraw: no grant, and either `vc_valid[p][held_vc]` = 0 or the target's credit bit = 0. Requests go to 0, state returns to IDLE, `rr_ptr` is unchanged.
  - Grant and withdraw condition in the same cycle: grant wins, because the allocator has already committed.
- Spurious grant: `allocated_ports[p]` is nonzero and does not equal `port_requests[p]`, or arrives while in IDLE. The grant is ignored, `grant_error` is set, and the state is unchanged.
- `vc_out_port` is sampled only at selection. Changes while in REQ are ignored.

## Timing
- Reset: all FSMs in IDLE, `rr_ptr` = 0, `held_vc` = 0. `port_requests`, `vc_dequeue`, `xbar_vc` and `grant_error` are all 0.
- Eligible VC present in IDLE at cycle t: request is visible at t+1.
- Grant sampled at cycle t: dequeue/xbar pulse at t+1 and request drops at t+1. The next request from the same port appears no earlier than t+2, so at most one grant per request.
- Withdraw sampled at t: request is 0 at t+1. A reselect can raise a new request at t+2.
- Allocator grant latency is unbounded; the request stays held until grant or withdraw.
- Reset asserted mid-REQ: returns to reset values on the next edge, with no dequeue pulse.
- Ports are fully independent. Any number of ports may request the same output in the same cycle.

## Test plan
- Reset: hold `reset` for 2 cycles with all inputs active. All outputs read 0, then the first request appears 1 cycle after deassert.
- Single request: port 0 VC2 valid, route 4'b0100, credit 4'b1111. Expect `port_requests[0]` = 4'b0100 at t+1. Grant 4'b0100 at t+3 gives `vc_dequeue[0]` = `xbar_vc[0]` = 4'b0100 for exactly one cycle at t+4, with the request at 0 on the same cycle.
- Round-robin: port 1 VCs 0–3 all valid, all routed 4'b0001, grants immediate. Expect dequeue order VC0, VC1, VC2, VC3, VC0, with one grant every 2 cycles.
- Withdraw: port 2 requesting 4'b1000, `out_credit[3]` drops with no grant. Request is 0 the next cycle, no dequeue, and `rr_ptr` unchanged. After the credit returns, the same VC re-requests.
- Simultaneous grant and credit drop: in the same cycle, the dequeue still pulses and `grant_error` stays 0.
- Spurious grant: port 3 in IDLE receives 4'b0010, or in REQ for 4'b0001 receives 4'b0011. `grant_error` = 1 and stays 1, with no dequeue and the FSM state unchanged.
